// File: rtl/am4_pkg.sv
// Shared definitions for the am4 carry-lookahead family: chain-state encoding
// and the width legality rule used by every multi-slice carry block.
package am4_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CHAIN = 1'b1
    } am4_chain_e;

    function automatic bit am4_w_legal(input int unsigned w);
        return (w >= 4) && (w <= 64) && ((w % 4) == 0);
    endfunction

endpackage

// File: rtl/am4_cla4.sv
// Combinational 4-bit carry-lookahead cell with active-low generate/propagate,
// producing per-bit carries and active-low group generate/propagate.
module am4_cla4 (
    input  logic       cin,
    input  logic [3:0] g_n,
    input  logic [3:0] p_n,
    output logic [3:0] c,
    output logic       gout_n,
    output logic       pout_n
);

    logic [3:0] g;
    logic [3:0] p;
    logic       gen;
    logic       prop;

    assign g = ~g_n;
    assign p = ~p_n;

    assign gen  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign prop = &p;

    assign c[0] = g[0] | (p[0] & cin);
    assign c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c[3] = gen | (prop & cin);

    assign gout_n = ~gen;
    assign pout_n = ~prop;

endmodule

// File: rtl/am4_cla_chain.sv
// Registered W-bit carry-lookahead slice with a one-entry output buffer and
// an IDLE/CHAIN tracker that carries c[W-1] between slices of a long operation.
module am4_cla_chain
    import am4_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         first,
    input  logic         last,
    input  logic         cin,
    input  logic [W-1:0] g_n,
    input  logic [W-1:0] p_n,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] cout,
    output logic         gout_n,
    output logic         pout_n,
    output logic         chain,
    output logic         seq_err
);

    localparam int unsigned NG = W / 4;

    if (!am4_w_legal(W)) begin : g_w_check
        $error("am4_cla_chain: W must be a multiple of 4 in 4..64");
    end

    am4_chain_e   state_q, state_d;
    logic         cy_q, cy_d;
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] cout_q, cout_d;
    logic         gout_n_q, gout_n_d;
    logic         pout_n_q, pout_n_d;
    logic         seq_err_q, seq_err_d;

    logic          accept;
    logic          cin_eff;
    logic [W-1:0]  c;
    logic [NG-1:0] grp_g_n, grp_p_n, grp_g, grp_p, grp_cin;
    logic          gen_all, prop_all;

    // Sum-of-products carry into group k: a lower group generates and every
    // group in between propagates, or ci propagates through all lower groups.
    function automatic logic grp_carry(input logic [NG-1:0] gg, input logic [NG-1:0] pp,
                                       input logic ci, input int unsigned k);
        logic res, term;
        res = 1'b0;
        for (int unsigned j = 0; j < k; j++) begin
            term = gg[j];
            for (int unsigned m = j + 1; m < k; m++) term = term & pp[m];
            res = res | term;
        end
        term = ci;
        for (int unsigned m = 0; m < k; m++) term = term & pp[m];
        return res | term;
    endfunction

    for (genvar k = 0; k < NG; k++) begin : g_cell
        am4_cla4 u_cla4 (
            .cin    (grp_cin[k]),
            .g_n    (g_n[4*k +: 4]),
            .p_n    (p_n[4*k +: 4]),
            .c      (c[4*k +: 4]),
            .gout_n (grp_g_n[k]),
            .pout_n (grp_p_n[k])
        );
    end

    assign grp_g = ~grp_g_n;
    assign grp_p = ~grp_p_n;

    always_comb begin
        grp_cin = '0;
        for (int unsigned k = 0; k < NG; k++) grp_cin[k] = grp_carry(grp_g, grp_p, cin_eff, k);
    end

    assign gen_all  = grp_carry(grp_g, grp_p, 1'b0, NG);
    assign prop_all = &grp_p;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign cin_eff  = first ? cin : ((state_q == ST_CHAIN) ? cy_q : 1'b0);

    always_comb begin
        state_d     = state_q;
        cy_d        = cy_q;
        cout_d      = cout_q;
        gout_n_d    = gout_n_q;
        pout_n_d    = pout_n_q;
        seq_err_d   = 1'b0;
        out_valid_d = out_valid_q && !out_ready;
        if (accept) begin
            out_valid_d = 1'b1;
            cout_d      = c;
            gout_n_d    = ~gen_all;
            pout_n_d    = ~prop_all;
            seq_err_d   = (first && (state_q == ST_CHAIN)) || (!first && (state_q == ST_IDLE));
            if (last) begin
                state_d = ST_IDLE;
                cy_d    = 1'b0;
            end else begin
                state_d = ST_CHAIN;
                cy_d    = c[W-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cy_q        <= 1'b0;
            out_valid_q <= 1'b0;
            cout_q      <= '0;
            gout_n_q    <= 1'b1;
            pout_n_q    <= 1'b1;
            seq_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cy_q        <= cy_d;
            out_valid_q <= out_valid_d;
            cout_q      <= cout_d;
            gout_n_q    <= gout_n_d;
            pout_n_q    <= pout_n_d;
            seq_err_q   <= seq_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign cout      = cout_q;
    assign gout_n    = gout_n_q;
    assign pout_n    = pout_n_q;
    assign seq_err   = seq_err_q;
    assign chain     = (state_q == ST_CHAIN);

endmodule
